// File: rtl/ofm_drain.sv
// Output row FIFO: one-cycle push into registered storage, out_vld whenever non-empty.
// Push is never refused (the drain credits guarantee space); pop on out_vld & out_rdy.
module ofm_drain_fifo #(
   parameter int DW    = 32,
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_vld,
   input  logic [DW-1:0] in_dat,
   output logic          out_vld,
   input  logic          out_rdy,
   output logic [DW-1:0] out_dat,
   output logic [CW-1:0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pop;

   assign out_vld = (cnt_q != '0);
   assign pop     = out_vld && out_rdy;
   assign out_dat = out_vld ? mem_q[rd_q] : '0;
   assign count   = cnt_q;

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (in_vld) begin
         mem_d[wr_q] = in_dat;
         wr_d = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      end
      if (pop) begin
         rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      end
      case ({in_vld, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
endmodule

// Drains a systolic array tile: skewed en_o/clr_o out, column-skewed ofm in, aligned rows out.
// Row push lands DRAIN_LAT+WIDTH-1 cycles after its beat; beats are credit-throttled by FIFO space.
module ofm_drain #(
   parameter int WIDTH      = 32,
   parameter int HEIGHT     = 32,
   parameter int OWIDTH     = 32,
   parameter int DRAIN_LAT  = 32,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic [WIDTH-1:0]         en_o,
   output logic [WIDTH-1:0]         clr_o,
   input  logic [WIDTH*OWIDTH-1:0]  ofm,
   output logic [WIDTH*OWIDTH-1:0]  out_data,
   output logic                     out_valid,
   input  logic                     out_ready
);
   localparam int BL = WIDTH + DRAIN_LAT;
   localparam int BW = $clog2(HEIGHT + 1);
   localparam int WW = $clog2(WIDTH + 1);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_FLUSH, S_CLEAR, S_WAITC} state_t;

   state_t                    state_q, state_d;
   logic [BW-1:0]             bcnt_q, bcnt_d;
   logic [WW-1:0]             wcnt_q, wcnt_d;
   logic [CW-1:0]             inflt_q, inflt_d;
   logic                      done_q, done_d;
   logic [BL-1:0]             bl_q, bl_d;
   logic [WIDTH-1:0]          cl_q, cl_d;
   logic                      beat_iss, clr_iss, credit_ok, push;
   logic [CW-1:0]             fifo_cnt;
   logic [WIDTH*OWIDTH-1:0]   row_dat;

   // bl_q[w] is en_o[w]; bl_q[w+DRAIN_LAT] is the capture strobe of column w.
   assign push      = bl_q[BL-1];
   assign credit_ok = ({1'b0, inflt_q} + {1'b0, fifo_cnt}) < DEPTH_C;
   assign en_o      = bl_q[WIDTH-1:0];
   assign clr_o     = cl_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;

   always_comb begin
      state_d  = state_q;
      bcnt_d   = bcnt_q;
      wcnt_d   = wcnt_q;
      done_d   = 1'b0;
      beat_iss = 1'b0;
      clr_iss  = 1'b0;
      // The first beat is decided in the start cycle so en_o[0] rises one cycle after start.
      if (state_q == S_IDLE && start) state_d = S_DRAIN;
      if ((state_q == S_DRAIN || (state_q == S_IDLE && start)) && credit_ok) begin
         beat_iss = 1'b1;
         if (bcnt_q == BW'(HEIGHT - 1)) begin
            bcnt_d  = '0;
            state_d = S_FLUSH;
         end else begin
            bcnt_d = bcnt_q + 1'b1;
         end
      end
      case (state_q)
         S_FLUSH: if (inflt_q == '0) state_d = S_CLEAR;
         S_CLEAR: begin
            clr_iss = 1'b1;
            wcnt_d  = '0;
            state_d = S_WAITC;
         end
         S_WAITC: begin
            if (wcnt_q == WW'(WIDTH - 1)) begin
               wcnt_d  = '0;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      bl_d    = {bl_q[BL-2:0], beat_iss};
      cl_d    = cl_q;
      cl_d[0] = clr_iss;
      for (int i = 1; i < WIDTH; i++) cl_d[i] = cl_q[i-1];
      case ({beat_iss, push})
         2'b10:   inflt_d = inflt_q + 1'b1;
         2'b01:   inflt_d = inflt_q - 1'b1;
         default: inflt_d = inflt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         bcnt_q  <= '0;
         wcnt_q  <= '0;
         inflt_q <= '0;
         done_q  <= 1'b0;
         bl_q    <= '0;
         cl_q    <= '0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         wcnt_q  <= wcnt_d;
         inflt_q <= inflt_d;
         done_q  <= done_d;
         bl_q    <= bl_d;
         cl_q    <= cl_d;
      end
   end

   for (genvar w = 0; w < WIDTH; w++) begin : g_col
      localparam int L = WIDTH - 1 - w;
      if (L == 0) begin : g_last
         assign row_dat[w*OWIDTH +: OWIDTH] = ofm[w*OWIDTH +: OWIDTH];
      end else begin : g_dly
         logic [OWIDTH-1:0] dl_q [L];
         logic [OWIDTH-1:0] dl_d [L];
         always_comb begin
            dl_d[0] = bl_q[w + DRAIN_LAT] ? ofm[w*OWIDTH +: OWIDTH] : dl_q[0];
            for (int j = 1; j < L; j++) dl_d[j] = dl_q[j-1];
         end
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               for (int j = 0; j < L; j++) dl_q[j] <= '0;
            end else begin
               dl_q <= dl_d;
            end
         end
         assign row_dat[w*OWIDTH +: OWIDTH] = dl_q[L-1];
      end
   end

   ofm_drain_fifo #(
      .DW    (WIDTH * OWIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_vld  (push),
      .in_dat  (row_dat),
      .out_vld (out_valid),
      .out_rdy (out_ready),
      .out_dat (out_data),
      .count   (fifo_cnt)
   );
endmodule

// File: tb/tb_ofm_drain.sv
// Bench for ofm_drain: two instances (FIFO depth 8 and 2) share stimulus; each has a
// behavioural array model that returns column values DRAIN_LAT cycles after en_o.
module tb_ofm_drain;
   localparam int W = 4, H = 4, DL = 4, OW = 32, NI = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n, start, out_ready;
   logic [W*OW-1:0]   ofm      [NI];
   logic [W*OW-1:0]   out_data [NI];
   logic [W-1:0]      en_o     [NI];
   logic [W-1:0]      clr_o    [NI];
   logic              busy [NI], done [NI], out_valid [NI];

   int n_cmp = 0, n_bad = 0, cyc = 0, t0 = 0;
   bit rnd_rdy = 0;
   logic [OW-1:0]   mat [H][W];
   logic [W*OW-1:0] exp_rows [$];
   int rd_idx [NI];
   int k [NI][W];
   int en_cnt [NI][W], en_first [NI][W], en_last [NI][W];
   int clr_cnt [NI][W], clr_first [NI][W];
   int done_cnt [NI];

   task automatic check(input string tag, input logic [W*OW:0] got, input logic [W*OW:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   for (genvar gi = 0; gi < NI; gi++) begin : g_inst
      ofm_drain #(
         .WIDTH(W), .HEIGHT(H), .OWIDTH(OW), .DRAIN_LAT(DL),
         .FIFO_DEPTH((gi == 0) ? 8 : 2)
      ) u_dut (
         .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[gi]), .done(done[gi]),
         .en_o(en_o[gi]), .clr_o(clr_o[gi]), .ofm(ofm[gi]), .out_data(out_data[gi]),
         .out_valid(out_valid[gi]), .out_ready(out_ready)
      );

      logic [OW-1:0]   sv [W][16];
      bit              sb [W][16];
      logic [W*OW-1:0] held;
      bit              stall;

      // Array model: a value scheduled for cycle n is presented on ofm[w] during cycle n.
      initial begin
         ofm[gi] = '0;
         stall = 0;
         for (int w = 0; w < W; w++) for (int s = 0; s < 16; s++) sb[w][s] = 0;
         forever begin
            @(posedge clk);
            #1;
            for (int w = 0; w < W; w++) begin
               if (sb[w][cyc % 16]) begin
                  ofm[gi][w*OW +: OW] = sv[w][cyc % 16];
                  sb[w][cyc % 16] = 0;
               end else begin
                  ofm[gi][w*OW +: OW] = $urandom;
               end
            end
         end
      end

      initial begin : mon
         int r, slot;
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               for (int w = 0; w < W; w++) for (int s = 0; s < 16; s++) sb[w][s] = 0;
               rd_idx[gi] = exp_rows.size();
               stall = 0;
            end else begin
               for (int w = 0; w < W; w++) begin
                  if (en_o[gi][w]) begin
                     r = k[gi][w];
                     k[gi][w]++;
                     if (en_cnt[gi][w] == 0) en_first[gi][w] = cyc;
                     en_last[gi][w] = cyc;
                     en_cnt[gi][w]++;
                     slot = (cyc + DL) % 16;
                     sv[w][slot] = (r < H) ? mat[r][w] : $urandom;
                     sb[w][slot] = 1;
                  end
                  if (clr_o[gi][w]) begin
                     if (clr_cnt[gi][w] == 0) clr_first[gi][w] = cyc;
                     clr_cnt[gi][w]++;
                  end
               end
               if (done[gi]) begin
                  done_cnt[gi]++;
                  check("busy_at_done", busy[gi], 0);
               end
               if (stall) check("hold", {out_valid[gi], out_data[gi]}, {1'b1, held});
               if (out_valid[gi] && out_ready) begin
                  if (rd_idx[gi] < exp_rows.size()) check("row", out_data[gi], exp_rows[rd_idx[gi]]);
                  else check("extra_row", rd_idx[gi], exp_rows.size() - 1);
                  rd_idx[gi]++;
               end
               stall = out_valid[gi] && !out_ready;
               held  = out_data[gi];
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
   endtask

   // mode 0: 100*r+w, mode 1: extreme values alternating, other: random
   task automatic start_tile(input int mode);
      logic [W*OW-1:0] row;
      for (int r = 0; r < H; r++) begin
         for (int w = 0; w < W; w++) begin
            if (mode == 0) mat[r][w] = OW'(100 * r + w);
            else if (mode == 1) mat[r][w] = ((r + w) % 2 != 0) ? 32'h7fff_ffff : 32'h8000_0000;
            else mat[r][w] = $urandom;
            row[w*OW +: OW] = mat[r][w];
         end
         exp_rows.push_back(row);
      end
      for (int i = 0; i < NI; i++) begin
         done_cnt[i] = 0;
         for (int w = 0; w < W; w++) begin
            k[i][w] = 0; en_cnt[i][w] = 0; clr_cnt[i][w] = 0;
         end
      end
      start = 1'b1;
      t0 = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!(done_cnt[0] > 0 && done_cnt[1] > 0) && n < budget) begin tick(); n++; end
      check("done_timeout", n < budget, 1);
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((rd_idx[0] < exp_rows.size() || rd_idx[1] < exp_rows.size()) && n < budget) begin
         tick(); n++;
      end
      check("drain_timeout", n < budget, 1);
   endtask

   task automatic check_tile_counts();
      for (int i = 0; i < NI; i++) begin
         check("done_once", done_cnt[i], 1);
         check("rows_all", rd_idx[i], exp_rows.size());
         for (int w = 0; w < W; w++) begin
            check("beats", en_cnt[i][w], H);
            check("clr_once", clr_cnt[i][w], 1);
            check("clr_skew", clr_first[i][w], clr_first[i][0] + w);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < NI; i++) rd_idx[i] = 0;
      repeat (3) tick();
      for (int i = 0; i < NI; i++) begin
         check("rst_busy", busy[i], 0);
         check("rst_done", done[i], 0);
         check("rst_en", en_o[i], 0);
         check("rst_clr", clr_o[i], 0);
         check("rst_vld", out_valid[i], 0);
         check("rst_data", out_data[i], 0);
      end
      rst_n = 1'b1;
      tick();

      // basic tile, consumer always ready
      out_ready = 1'b1;
      start_tile(0);
      wait_done(300);
      wait_drain(300);
      repeat (5) tick();
      for (int w = 0; w < W; w++) begin
         check("en_first", en_first[0][w], t0 + 1 + w);
         check("en_last", en_last[0][w], t0 + H + w);
      end
      check_tile_counts();

      // consumer stalled: depth-2 instance must freeze after two beats
      out_ready = 1'b0;
      start_tile(2);
      repeat (60) tick();
      for (int w = 0; w < W; w++) begin
         check("frozen_d2", en_cnt[1][w], 2);
         check("beats_d8", en_cnt[0][w], H);
      end
      check("stall_vld", out_valid[1], 1);
      check("stall_busy", busy[1], 1);
      out_ready = 1'b1;
      wait_done(400);
      wait_drain(400);
      repeat (5) tick();
      check_tile_counts();

      // start pulses during DRAIN and FLUSH are ignored
      start_tile(2);
      tick(); start = 1'b1; tick(); start = 1'b0;
      repeat (4) tick();
      start = 1'b1; tick(); start = 1'b0;
      wait_done(400);
      wait_drain(400);
      repeat (30) tick();
      check_tile_counts();
      for (int i = 0; i < NI; i++) check("idle_after", busy[i], 0);

      // reset in the middle of a drain
      start_tile(2);
      tick();
      rst_n = 1'b0;
      tick();
      for (int i = 0; i < NI; i++) begin
         check("mid_rst_en", en_o[i], 0);
         check("mid_rst_clr", clr_o[i], 0);
         check("mid_rst_vld", out_valid[i], 0);
         check("mid_rst_busy", busy[i], 0);
      end
      rst_n = 1'b1;
      repeat (3) tick();
      start_tile(0);
      wait_done(300);
      wait_drain(300);
      repeat (5) tick();
      check_tile_counts();

      // full-scale signed extremes
      start_tile(1);
      wait_done(300);
      wait_drain(300);
      repeat (5) tick();
      check_tile_counts();

      // back-to-back tiles with a randomly stalling consumer
      rnd_rdy = 1;
      for (int t = 0; t < 3; t++) begin
         start_tile(2);
         wait_done(1500);
         for (int i = 0; i < NI; i++) check("b2b_done", done_cnt[i], 1);
      end
      wait_drain(2000);
      rnd_rdy = 0;
      out_ready = 1'b1;
      repeat (10) tick();
      for (int i = 0; i < NI; i++) check("b2b_rows", rd_idx[i], exp_rows.size());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
